io_uart_fifo: RTL and testbench

Parametrised IO-bus UART register block with a TX FIFO, an RX FIFO and a level interrupt. It replaces the single-character UART output/RX latch on the DMA/IO bus. Software writes bursts of characters without polling per byte, and received characters queue while the CPU runs. It sits between the IO bus daisy chain (read-data pass-through) and the UART TX/RX serialisers.

---
 rtl/uart_io_pkg.sv | 44 ++++
 rtl/io_uart_sfifo.sv | 64 ++++++
 rtl/io_uart_fifo.sv | 189 ++++++++++++++++++
 tb/tb_io_uart_fifo.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_io_pkg.sv
// Shared constants for the IO-bus UART register block: register word offsets,
// STATUS/CTRL bit positions and the reset baud terms selected by init_uart.
package uart_io_pkg;

    // Register word offsets from BASE_ADR
    localparam logic [13:0] RegTxData = 14'd0;
    localparam logic [13:0] RegStatus = 14'd1;
    localparam logic [13:0] RegTerm   = 14'd2;
    localparam logic [13:0] RegRxData = 14'd3;
    localparam logic [13:0] RegCtrl   = 14'd4;

    // STATUS bit positions; [15:8] tx_count, [23:16] rx_count
    localparam int unsigned StTxFull     = 0;
    localparam int unsigned StTxEmpty    = 1;
    localparam int unsigned StRxEmpty    = 2;
    localparam int unsigned StRxFull     = 3;
    localparam int unsigned StRxOverrun  = 4;
    localparam int unsigned StTxOverflow = 5;

    // CTRL bit positions; the flush bits are write-1 pulses, never stored
    localparam int unsigned CtrlEchoDis = 0;
    localparam int unsigned CtrlTxIe    = 1;
    localparam int unsigned CtrlRxIe    = 2;
    localparam int unsigned CtrlRxFlush = 3;
    localparam int unsigned CtrlTxFlush = 4;

    // Reset baud divider terms
    localparam logic [15:0] Term0 = 16'd109;
    localparam logic [15:0] Term1 = 16'd54;
    localparam logic [15:0] Term2 = 16'd5208;
    localparam logic [15:0] Term3 = 16'd5000;

    function automatic logic [15:0] init_term(input logic [1:0] sel);
        logic [15:0] t;
        case (sel)
            2'd0:    t = Term0;
            2'd1:    t = Term1;
            2'd2:    t = Term2;
            default: t = Term3;
        endcase
        return t;
    endfunction

endpackage

// File: rtl/io_uart_sfifo.sv
// Synchronous FIFO with registered count.
//   push_i/data_i : enqueue (ignored when full)
//   pop_i         : dequeue head (ignored when empty)
//   flush_i       : clear pointers and count, overrides push/pop
//   head_o        : current head entry (read-before-write)
//   count_o, full_o, empty_o : occupancy
module io_uart_sfifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output logic [WIDTH-1:0] head_o,
    output logic [7:0]       count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [7:0]       count_q;
    logic             push_ok, pop_ok;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrW'(1);
    endfunction

    assign full_o  = (count_q == 8'(DEPTH));
    assign empty_o = (count_q == 8'd0);
    assign count_o = count_q;
    assign head_o  = mem_q[rptr_q];

    assign push_ok = push_i & ~full_o & ~flush_i;
    assign pop_ok  = pop_i & ~empty_o & ~flush_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push_ok) wptr_q <= ptr_inc(wptr_q);
            if (pop_ok)  rptr_q <= ptr_inc(rptr_q);
            count_q <= count_q + 8'(push_ok) - 8'(pop_ok);
        end
    end

    // Storage needs no reset: the pointers define what is valid
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wptr_q] <= data_i;
    end

endmodule

// File: rtl/io_uart_fifo.sv
// IO-bus UART register block with TX/RX FIFOs and a level interrupt.
//   dma_io_*   : IO bus write port, read port and daisy-chain read data
//   uart_io_*  : TX serialiser handshake (char, one-cycle strobe, busy)
//   rout_en/rout, cpu_run_state : received characters
//   uart_term  : baud divider, uart_irq : level interrupt
module io_uart_fifo
    import uart_io_pkg::*;
#(
    parameter logic [13:0] BASE_ADR = 14'h3F00,
    parameter int unsigned TX_DEPTH = 8,
    parameter int unsigned RX_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dma_io_we,
    input  logic [13:0] dma_io_wadr,
    input  logic [31:0] dma_io_wdata,
    input  logic [13:0] dma_io_radr,
    input  logic        dma_io_radr_en,
    input  logic [31:0] dma_io_rdata_in,
    output logic [31:0] dma_io_rdata,
    output logic [7:0]  uart_io_char,
    output logic        uart_io_we,
    input  logic        uart_io_full,
    input  logic [1:0]  init_uart,
    output logic [15:0] uart_term,
    input  logic        cpu_run_state,
    input  logic        rout_en,
    input  logic [7:0]  rout,
    output logic        ext_uart_interrpt_1shot,
    output logic        uart_irq,
    output logic        rx_disable_echoback
);

    localparam logic [13:0] AdrTx   = BASE_ADR + RegTxData;
    localparam logic [13:0] AdrStat = BASE_ADR + RegStatus;
    localparam logic [13:0] AdrTerm = BASE_ADR + RegTerm;
    localparam logic [13:0] AdrRx   = BASE_ADR + RegRxData;
    localparam logic [13:0] AdrCtrl = BASE_ADR + RegCtrl;

    logic [7:0]  last_tx_q, uart_char_q;
    logic        uart_we_q;
    logic [15:0] term_q, term_d;
    logic [1:0]  init_cnt_q;
    logic        echo_dis_q, tx_ie_q, rx_ie_q;
    logic        rx_ovr_q, rx_ovr_d, tx_ovf_q, tx_ovf_d;
    logic [31:0] rdata_q, rd_val;
    logic        rd_sel_q, rd_hit;

    logic        wr_tx, wr_term, wr_ctrl, rd_status, rd_rx;
    logic        tx_flush, rx_flush, tx_pop, rx_push, rx_pop;
    logic [7:0]  tx_head, rx_head, tx_cnt, rx_cnt;
    logic        tx_full, tx_empty, rx_full, rx_empty;
    logic [31:0] status_w;
    logic        unused_wdata;

    assign unused_wdata = ^dma_io_wdata[31:16];

    assign wr_tx     = dma_io_we & (dma_io_wadr == AdrTx);
    assign wr_term   = dma_io_we & (dma_io_wadr == AdrTerm);
    assign wr_ctrl   = dma_io_we & (dma_io_wadr == AdrCtrl);
    assign rd_status = dma_io_radr_en & (dma_io_radr == AdrStat);
    assign rd_rx     = dma_io_radr_en & (dma_io_radr == AdrRx);

    assign tx_flush = wr_ctrl & dma_io_wdata[CtrlTxFlush];
    assign rx_flush = wr_ctrl & dma_io_wdata[CtrlRxFlush];

    // Drain gated by last cycle's strobe gives one char per 2 cycles max
    assign tx_pop  = ~tx_empty & ~uart_io_full & ~uart_we_q & ~tx_flush;
    assign rx_push = cpu_run_state & rout_en;
    assign rx_pop  = rd_rx & ~rx_empty;

    io_uart_sfifo #(
        .WIDTH(8),
        .DEPTH(TX_DEPTH)
    ) u_tx_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (wr_tx),
        .data_i (dma_io_wdata[7:0]),
        .pop_i  (tx_pop),
        .flush_i(tx_flush),
        .head_o (tx_head),
        .count_o(tx_cnt),
        .full_o (tx_full),
        .empty_o(tx_empty)
    );

    io_uart_sfifo #(
        .WIDTH(8),
        .DEPTH(RX_DEPTH)
    ) u_rx_fifo (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .push_i (rx_push),
        .data_i (rout),
        .pop_i  (rx_pop),
        .flush_i(rx_flush),
        .head_o (rx_head),
        .count_o(rx_cnt),
        .full_o (rx_full),
        .empty_o(rx_empty)
    );

    // Sticky flags: a set in the same cycle as a STATUS read wins
    assign rx_ovr_d = (rx_push & rx_full) | (rx_ovr_q & ~rd_status);
    assign tx_ovf_d = (wr_tx & tx_full) | (tx_ovf_q & ~rd_status);

    // The init term is forced for the first two edges after reset release
    always_comb begin
        term_d = term_q;
        if (init_cnt_q != 2'd2) begin
            term_d = init_term(init_uart);
        end else if (wr_term) begin
            term_d = dma_io_wdata[15:0];
        end
    end

    always_comb begin
        status_w               = '0;
        status_w[StTxFull]     = tx_full;
        status_w[StTxEmpty]    = tx_empty;
        status_w[StRxEmpty]    = rx_empty;
        status_w[StRxFull]     = rx_full;
        status_w[StRxOverrun]  = rx_ovr_q;
        status_w[StTxOverflow] = tx_ovf_q;
        status_w[15:8]         = tx_cnt;
        status_w[23:16]        = rx_cnt;
    end

    always_comb begin
        rd_val = '0;
        rd_hit = 1'b1;
        if (dma_io_radr == AdrTx) begin
            rd_val = {24'd0, last_tx_q};
        end else if (dma_io_radr == AdrStat) begin
            rd_val = status_w;
        end else if (dma_io_radr == AdrTerm) begin
            rd_val = {16'd0, term_q};
        end else if (dma_io_radr == AdrRx) begin
            rd_val = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
        end else if (dma_io_radr == AdrCtrl) begin
            rd_val = {29'd0, rx_ie_q, tx_ie_q, echo_dis_q};
        end else begin
            rd_hit = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_tx_q   <= '0;
            uart_char_q <= '0;
            uart_we_q   <= 1'b0;
            term_q      <= '0;
            init_cnt_q  <= '0;
            echo_dis_q  <= 1'b0;
            tx_ie_q     <= 1'b0;
            rx_ie_q     <= 1'b0;
            rx_ovr_q    <= 1'b0;
            tx_ovf_q    <= 1'b0;
            rdata_q     <= '0;
            rd_sel_q    <= 1'b0;
        end else begin
            if (wr_tx) last_tx_q <= dma_io_wdata[7:0];
            if (tx_pop) uart_char_q <= tx_head;
            uart_we_q <= tx_pop;
            term_q    <= term_d;
            if (init_cnt_q != 2'd2) init_cnt_q <= init_cnt_q + 2'd1;
            if (wr_ctrl) begin
                echo_dis_q <= dma_io_wdata[CtrlEchoDis];
                tx_ie_q    <= dma_io_wdata[CtrlTxIe];
                rx_ie_q    <= dma_io_wdata[CtrlRxIe];
            end
            rx_ovr_q <= rx_ovr_d;
            tx_ovf_q <= tx_ovf_d;
            rdata_q  <= rd_val;
            rd_sel_q <= dma_io_radr_en & rd_hit;
        end
    end

    assign dma_io_rdata            = rd_sel_q ? rdata_q : dma_io_rdata_in;
    assign uart_io_char            = uart_char_q;
    assign uart_io_we              = uart_we_q;
    assign uart_term               = term_q;
    assign ext_uart_interrpt_1shot = cpu_run_state & rout_en;
    assign rx_disable_echoback     = echo_dis_q & cpu_run_state;
    assign uart_irq                = (rx_ie_q & ~rx_empty) | (tx_ie_q & tx_empty);

endmodule

// File: tb/tb_io_uart_fifo.sv
// Directed bench for io_uart_fifo: reset/init term, TX drain and overflow,
// RX queue and overrun, interrupts, push/pop collision, flush, pass-through.
module tb_io_uart_fifo;

    localparam logic [13:0] ATx   = 14'h3F00;
    localparam logic [13:0] AStat = 14'h3F01;
    localparam logic [13:0] ATerm = 14'h3F02;
    localparam logic [13:0] ARx   = 14'h3F03;
    localparam logic [13:0] ACtrl = 14'h3F04;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic        dma_io_radr_en;
    logic [31:0] dma_io_rdata_in;
    logic [31:0] dma_io_rdata;
    logic [7:0]  uart_io_char;
    logic        uart_io_we;
    logic        uart_io_full;
    logic [1:0]  init_uart;
    logic [15:0] uart_term;
    logic        cpu_run_state;
    logic        rout_en;
    logic [7:0]  rout;
    logic        ext_uart_interrpt_1shot;
    logic        uart_irq;
    logic        rx_disable_echoback;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [7:0] txq[$];
    int         txc[$];
    logic [31:0] rd;

    io_uart_fifo #(
        .BASE_ADR(14'h3F00),
        .TX_DEPTH(8),
        .RX_DEPTH(8)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .dma_io_we              (dma_io_we),
        .dma_io_wadr            (dma_io_wadr),
        .dma_io_wdata           (dma_io_wdata),
        .dma_io_radr            (dma_io_radr),
        .dma_io_radr_en         (dma_io_radr_en),
        .dma_io_rdata_in        (dma_io_rdata_in),
        .dma_io_rdata           (dma_io_rdata),
        .uart_io_char           (uart_io_char),
        .uart_io_we             (uart_io_we),
        .uart_io_full           (uart_io_full),
        .init_uart              (init_uart),
        .uart_term              (uart_term),
        .cpu_run_state          (cpu_run_state),
        .rout_en                (rout_en),
        .rout                   (rout),
        .ext_uart_interrpt_1shot(ext_uart_interrpt_1shot),
        .uart_irq               (uart_irq),
        .rx_disable_echoback    (rx_disable_echoback)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every TX strobe with its cycle number
    always @(negedge clk) begin
        if (rst_n && uart_io_we) begin
            txq.push_back(uart_io_char);
            txc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input logic [13:0] adr, input logic [31:0] data);
        dma_io_we    = 1'b1;
        dma_io_wadr  = adr;
        dma_io_wdata = data;
        tick();
        dma_io_we    = 1'b0;
    endtask

    task automatic bus_read(input logic [13:0] adr, output logic [31:0] data);
        dma_io_radr_en = 1'b1;
        dma_io_radr    = adr;
        tick();
        dma_io_radr_en = 1'b0;
        data = dma_io_rdata;
    endtask

    task automatic wait_tx(input int n, input int budget);
        for (int i = 0; i < budget && txq.size() < n; i++) tick();
        chk("tx_emitted_count", 32'(txq.size()), 32'(n));
    endtask

    initial begin
        rst_n = 1'b0;
        dma_io_we = 1'b0;
        dma_io_wadr = '0;
        dma_io_wdata = '0;
        dma_io_radr = '0;
        dma_io_radr_en = 1'b0;
        dma_io_rdata_in = 32'hCAFE_F00D;
        uart_io_full = 1'b0;
        init_uart = 2'd2;
        cpu_run_state = 1'b0;
        rout_en = 1'b0;
        rout = '0;

        // Reset state
        #1;
        chk("reset_term", 32'(uart_term), 32'd0);
        chk("reset_we", 32'(uart_io_we), 32'd0);
        chk("reset_irq", 32'(uart_irq), 32'd0);
        chk("reset_rdata_pass", dma_io_rdata, 32'hCAFE_F00D);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("init_term_edge1", 32'(uart_term), 32'd5208);
        tick();
        chk("init_term_edge2", 32'(uart_term), 32'd5208);
        bus_read(AStat, rd);
        chk("status_after_reset", rd, 32'h0000_0006);

        // TX drain: nine chars, one every two cycles
        txq.delete();
        txc.delete();
        for (int i = 0; i < 9; i++) bus_write(ATx, 32'h41 + 32'(i));
        wait_tx(9, 40);
        for (int i = 0; i < 9; i++) chk("tx_char", 32'(txq[i]), 32'h41 + 32'(i));
        for (int i = 1; i < 9; i++) chk("tx_gap", 32'(txc[i] - txc[i-1]), 32'd2);
        bus_read(ATx, rd);
        chk("txdata_readback", rd, 32'h0000_0049);

        // TX overflow with serialiser busy
        txq.delete();
        txc.delete();
        uart_io_full = 1'b1;
        for (int i = 0; i < 9; i++) bus_write(ATx, 32'h41 + 32'(i));
        bus_read(AStat, rd);
        chk("status_tx_overflow", rd, 32'h0000_0825);
        bus_read(AStat, rd);
        chk("status_ovf_cleared", rd, 32'h0000_0805);
        chk("no_tx_while_busy", 32'(txq.size()), 32'd0);
        uart_io_full = 1'b0;
        wait_tx(8, 40);
        for (int i = 0; i < 8; i++) chk("tx_char_ovf", 32'(txq[i]), 32'h41 + 32'(i));
        repeat (10) tick();
        chk("tx_no_ninth", 32'(txq.size()), 32'd8);

        // RX queue, overrun and interrupt
        bus_write(ACtrl, 32'h4);
        chk("irq_rx_idle", 32'(uart_irq), 32'd0);
        cpu_run_state = 1'b1;
        rout_en = 1'b1;
        rout = 8'h30;
        #1;
        chk("oneshot_high", 32'(ext_uart_interrpt_1shot), 32'd1);
        tick();
        chk("irq_after_first_push", 32'(uart_irq), 32'd1);
        for (int i = 1; i < 9; i++) begin
            rout = 8'h30 + 8'(i);
            tick();
        end
        rout_en = 1'b0;
        bus_read(AStat, rd);
        chk("status_rx_overrun", rd, 32'h0008_001A);
        for (int i = 0; i < 8; i++) begin
            bus_read(ARx, rd);
            chk("rxdata", rd, 32'h130 + 32'(i));
            if (i == 6) chk("irq_before_last_pop", 32'(uart_irq), 32'd1);
            if (i == 7) chk("irq_after_last_pop", 32'(uart_irq), 32'd0);
        end
        bus_read(ARx, rd);
        chk("rxdata_empty", rd, 32'h0);
        bus_read(AStat, rd);
        chk("status_ovr_cleared", rd, 32'h0000_0006);
        bus_read(ACtrl, rd);
        chk("ctrl_readback", rd, 32'h4);

        // Echo-back disable and gating by cpu_run_state
        bus_write(ACtrl, 32'h5);
        #1;
        chk("echo_dis_run", 32'(rx_disable_echoback), 32'd1);
        cpu_run_state = 1'b0;
        #1;
        chk("echo_dis_halt", 32'(rx_disable_echoback), 32'd0);
        rout_en = 1'b1;
        rout = 8'h77;
        #1;
        chk("oneshot_halt", 32'(ext_uart_interrpt_1shot), 32'd0);
        tick();
        rout_en = 1'b0;
        bus_read(AStat, rd);
        chk("no_rx_when_halted", rd, 32'h0000_0006);

        // Concurrent push and pop on a 1-entry RX FIFO
        cpu_run_state = 1'b1;
        rout_en = 1'b1;
        rout = 8'h55;
        tick();
        rout = 8'h66;
        bus_read(ARx, rd);
        rout_en = 1'b0;
        chk("collision_old_head", rd, 32'h155);
        bus_read(AStat, rd);
        chk("collision_count", rd, 32'h0001_0002);
        bus_read(ARx, rd);
        chk("collision_new_head", rd, 32'h166);

        // TX empty interrupt
        bus_write(ACtrl, 32'h2);
        chk("irq_tx_empty", 32'(uart_irq), 32'd1);
        uart_io_full = 1'b1;
        bus_write(ATx, 32'h5A);
        chk("irq_tx_nonempty", 32'(uart_irq), 32'd0);

        // Flush both FIFOs while the TX drain is active
        for (int i = 0; i < 4; i++) bus_write(ATx, 32'h61 + 32'(i));
        rout_en = 1'b1;
        rout = 8'h70;
        tick();
        rout = 8'h71;
        tick();
        rout_en = 1'b0;
        txq.delete();
        txc.delete();
        uart_io_full = 1'b0;
        tick();
        tick();
        bus_write(ACtrl, 32'h18);
        bus_read(AStat, rd);
        chk("status_after_flush", rd, 32'h0000_0006);
        repeat (10) tick();
        chk("flush_tx_pulses", 32'(txq.size()), 32'd1);
        chk("flush_first_char", 32'(txq[0]), 32'h5A);
        bus_read(ACtrl, rd);
        chk("ctrl_flush_reads_zero", rd, 32'h0);

        // Unselected read passes upstream data through
        dma_io_rdata_in = 32'h1234_5678;
        bus_read(14'h0100, rd);
        chk("unselected_read", rd, 32'h1234_5678);
        bus_read(AStat, rd);
        tick();
        chk("idle_pass_through", dma_io_rdata, 32'h1234_5678);

        // Reset mid-operation, new init term, TERM write override window
        rout_en = 1'b1;
        rout = 8'h42;
        tick();
        rout_en = 1'b0;
        cpu_run_state = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midreset_term", 32'(uart_term), 32'd0);
        init_uart = 2'd1;
        tick();
        rst_n = 1'b1;
        bus_write(ATerm, 32'hBEEF);
        chk("term_init_override", 32'(uart_term), 32'd54);
        tick();
        chk("term_init_edge2", 32'(uart_term), 32'd54);
        bus_write(ATerm, 32'h1234);
        chk("term_written", 32'(uart_term), 32'h1234);
        bus_read(ATerm, rd);
        chk("term_readback", rd, 32'h1234);
        bus_read(AStat, rd);
        chk("status_after_midreset", rd, 32'h0000_0006);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
